// File: rtl/hxd_host_pkg.sv
// Shared definitions for the debug-loader host side and the loader command parser:
// opcodes, frame sequencer states and the opcode legality check.
package hxd_host_pkg;

  typedef enum logic [7:0] {
    CPU_RST = 8'h2a,
    CPU_RUN = 8'h2b,
    CONF_WR = 8'h2c,
    CONF_RD = 8'h2d,
    DATA_WR = 8'h2e,
    DATA_RD = 8'h2f
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    CONF,
    PAY_REQ,
    SEND,
    DRAIN,
    DONE
  } state_t;

  function automatic logic cmd_legal(input logic [7:0] op);
    return (op >= 8'h2a) && (op <= 8'h2f);
  endfunction

endpackage

// File: rtl/host_byte_tx.sv
// Single-byte handshake toward uart_tx: presents a byte until it is taken, then
// waits for the transmitter to go busy so a late-falling ready cannot resend it.
module host_byte_tx
  import hxd_host_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] byte_i,
  input  logic       start_i,
  output logic       ack_o,
  output logic [7:0] uart_tx_data_o,
  output logic       uart_tx_data_vld_o,
  input  logic       uart_tx_data_rdy_i
);

  state_t state_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q            <= IDLE;
      uart_tx_data_o     <= 8'h00;
      uart_tx_data_vld_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            uart_tx_data_o     <= byte_i;
            uart_tx_data_vld_o <= 1'b1;
            state_q            <= SEND;
          end
        end
        SEND: begin
          if (uart_tx_data_rdy_i) begin
            uart_tx_data_vld_o <= 1'b0;
            state_q            <= DRAIN;
          end
        end
        DRAIN: begin
          if (!uart_tx_data_rdy_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ack on the same edge DRAIN exits so the frame FSM can start the next byte a cycle later.
  assign ack_o = (state_q == DRAIN) && !uart_tx_data_rdy_i;

endmodule

// File: rtl/host_cmd_gen.sv
// Host-side command sequencer: turns command requests into debug-loader byte
// frames (opcode, optional address/length or payload) streamed into uart_tx.
module host_cmd_gen
  import hxd_host_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [7:0]      cmd_i,
  input  logic [XLEN-1:0] cmd_addr_i,
  input  logic [XLEN-1:0] cmd_len_i,
  input  logic            cmd_vld_i,
  output logic            cmd_rdy_o,
  input  logic [7:0]      pay_data_i,
  input  logic            pay_vld_i,
  output logic            pay_rdy_o,
  output logic [7:0]      uart_tx_data_o,
  output logic            uart_tx_data_vld_o,
  input  logic            uart_tx_data_rdy_i,
  output logic            done_o,
  output logic            err_o
);

  localparam int CONF_BYTES = 2 * (XLEN / 8);
  localparam int IDXW       = $clog2(CONF_BYTES);

  state_t            state_q, ret_q;
  cmd_t              opc_q;
  logic [XLEN-1:0]   addr_q, len_q, cnt_q;
  logic [IDXW-1:0]   idx_q;
  logic              cmd_rdy_q, pay_rdy_q, done_q, err_q;
  logic              tx_start, tx_ack, pay_acc;
  logic [7:0]        tx_byte;
  logic [2*XLEN-1:0] conf_word;

  assign conf_word = {len_q, addr_q};
  assign pay_acc   = pay_vld_i && pay_rdy_q;

  always_comb begin
    tx_start = 1'b0;
    tx_byte  = opc_q;
    case (state_q)
      OPC:     tx_start = 1'b1;
      CONF: begin
        tx_start = 1'b1;
        tx_byte  = conf_word[{idx_q, 3'b000} +: 8];
      end
      PAY_REQ: begin
        tx_start = pay_acc;
        tx_byte  = pay_data_i;
      end
      default: ;
    endcase
  end

  // SEND covers the whole byte handshake; ret_q says where the frame continues.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      opc_q     <= CPU_RST;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      cmd_rdy_q <= 1'b0;
      pay_rdy_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_rdy_q <= 1'b1;
          if (cmd_vld_i && cmd_rdy_q) begin
            if (cmd_legal(cmd_i)) begin
              opc_q     <= cmd_t'(cmd_i);
              cmd_rdy_q <= 1'b0;
              state_q   <= OPC;
              if (cmd_i == CONF_WR) begin
                addr_q <= cmd_addr_i;
                len_q  <= cmd_len_i;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        OPC: begin
          idx_q   <= '0;
          cnt_q   <= len_q;
          state_q <= SEND;
          case (opc_q)
            CONF_WR: ret_q <= CONF;
            DATA_WR: ret_q <= PAY_REQ;
            default: ret_q <= DONE;
          endcase
        end
        CONF: begin
          idx_q   <= idx_q + IDXW'(1);
          state_q <= SEND;
          ret_q   <= (idx_q == IDXW'(CONF_BYTES - 1)) ? DONE : CONF;
        end
        PAY_REQ: begin
          // Terminal test on the pre-decrement count keeps a full-range length from wrapping early.
          if (pay_acc) begin
            pay_rdy_q <= 1'b0;
            cnt_q     <= cnt_q - XLEN'(1);
            state_q   <= SEND;
            ret_q     <= (cnt_q == '0) ? DONE : PAY_REQ;
          end
        end
        SEND: begin
          if (tx_ack) begin
            state_q <= ret_q;
            if (ret_q == DONE)    done_q    <= 1'b1;
            if (ret_q == PAY_REQ) pay_rdy_q <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          cmd_rdy_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_rdy_o = cmd_rdy_q;
  assign pay_rdy_o = pay_rdy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

  host_byte_tx u_byte_tx (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .byte_i             (tx_byte),
    .start_i            (tx_start),
    .ack_o              (tx_ack),
    .uart_tx_data_o     (uart_tx_data_o),
    .uart_tx_data_vld_o (uart_tx_data_vld_o),
    .uart_tx_data_rdy_i (uart_tx_data_rdy_i)
  );

endmodule

// File: tb/tb_host_cmd_gen.sv
// Bench for host_cmd_gen: directed and randomized frames against a byte-level
// frame model, with a uart_tx responder whose ready hold/busy times are adjustable.
module tb_host_cmd_gen;
  import hxd_host_pkg::*;

  localparam int XLEN = 32;
  localparam int NB   = XLEN / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      cmd;
  logic [XLEN-1:0] cmd_addr, cmd_len;
  logic            cmd_vld;
  logic            cmd_rdy;
  logic [7:0]      pay_data;
  logic            pay_vld;
  logic            pay_rdy;
  logic [7:0]      tx_data;
  logic            tx_vld;
  logic            tx_rdy;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;

  logic [7:0]      obs_q[$];
  logic [7:0]      exp_q[$];
  logic [XLEN-1:0] len_model;
  int              done_cnt = 0, err_cnt = 0, pay_hs_cnt = 0;
  int              hold_cfg = 0, busy_cfg = 2;
  int              hold_left = 0, busy_left = 0;
  logic            last_vld = 1'b0, last_rdy = 1'b0;
  logic [7:0]      last_data = 8'h00;

  host_cmd_gen #(.XLEN(XLEN)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .cmd_i              (cmd),
    .cmd_addr_i         (cmd_addr),
    .cmd_len_i          (cmd_len),
    .cmd_vld_i          (cmd_vld),
    .cmd_rdy_o          (cmd_rdy),
    .pay_data_i         (pay_data),
    .pay_vld_i          (pay_vld),
    .pay_rdy_o          (pay_rdy),
    .uart_tx_data_o     (tx_data),
    .uart_tx_data_vld_o (tx_vld),
    .uart_tx_data_rdy_i (tx_rdy),
    .done_o             (done),
    .err_o              (err)
  );

  always #5 clk = ~clk;

  // uart_tx responder and monitor: values seen at one negedge were sampled by the next posedge.
  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_vld  = 1'b0;
        last_rdy  = 1'b0;
        hold_left = 0;
        busy_left = 0;
        tx_rdy    = 1'b1;
      end else begin
        if (last_vld && last_rdy) begin
          obs_q.push_back(last_data);
          hold_left = hold_cfg;
          busy_left = busy_cfg;
        end
        if (hold_left > 0) begin
          tx_rdy = 1'b1;
          hold_left--;
        end else if (busy_left > 0) begin
          tx_rdy = 1'b0;
          busy_left--;
        end else begin
          tx_rdy = 1'b1;
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (pay_vld && pay_rdy) pay_hs_cnt++;
        last_vld  = tx_vld;
        last_rdy  = tx_rdy;
        last_data = tx_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] l);
    int n = 0;
    cmd      = op;
    cmd_addr = a;
    cmd_len  = l;
    cmd_vld  = 1'b1;
    while (!cmd_rdy && n < 200) begin
      step();
      n++;
    end
    check("cmd_accept_timeout", 64'(n < 200), 1);
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_done_timeout"}, 64'(n < 3000), 1);
    step();
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_cmd_rdy_back"}, cmd_rdy, 1);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_frame_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Full legal frame: model the expected bytes, drive the request and payload, compare.
  task automatic run_legal(input string tag, input logic [7:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] l, input bit fixed_pay, input int gap1, input int gap2);
    logic [7:0] prefix [8];
    logic [7:0] b;
    int d0, h0, n, w, hi;
    prefix = '{8'h55, 8'haa, 8'h55, 8'hcc, 8'h01, 8'h0b, 8'h0c, 8'h0d};
    d0 = done_cnt;
    exp_q.push_back(op);
    if (op == CONF_WR) begin
      for (int i = 0; i < NB; i++) exp_q.push_back(8'(a >> (8 * i)));
      for (int i = 0; i < NB; i++) exp_q.push_back(8'(l >> (8 * i)));
      len_model = l;
    end
    send_cmd(op, a, l);
    check({tag, "_opc_not_yet"}, tx_vld, 0);
    step();
    check({tag, "_opc_vld"}, tx_vld, 1);
    check({tag, "_opc_data"}, tx_data, op);
    if (op == DATA_WR) begin
      h0 = pay_hs_cnt;
      n  = int'(len_model) + 1;
      for (int i = 0; i < n; i++) begin
        if (i == gap1 || i == gap2) begin
          hi = 0;
          for (int c = 0; c < 20; c++) begin
            step();
            if (c >= 12 && tx_vld) hi++;
          end
          check({tag, "_gap_vld_low"}, hi, 0);
        end
        b = (fixed_pay && i < 8) ? prefix[i] : 8'($urandom);
        exp_q.push_back(b);
        pay_data = b;
        pay_vld  = 1'b1;
        w = 0;
        while (!pay_rdy && w < 500) begin
          step();
          w++;
        end
        if (w >= 500) check({tag, "_pay_timeout"}, 0, 1);
        step();
        pay_vld = 1'b0;
      end
      wait_done(tag);
      check({tag, "_pay_handshakes"}, pay_hs_cnt - h0, n);
    end else begin
      wait_done(tag);
    end
    check({tag, "_done_count"}, done_cnt - d0, 1);
    compare_frame(tag);
  endtask

  task automatic run_illegal(input string tag, input logic [7:0] op);
    int e0, hi;
    e0 = err_cnt;
    send_cmd(op, '0, '0);
    check({tag, "_err_pulse"}, err, 1);
    check({tag, "_cmd_rdy_kept"}, cmd_rdy, 1);
    hi = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (tx_vld) hi++;
    end
    check({tag, "_err_one_cycle"}, err_cnt - e0, 1);
    check({tag, "_no_vld"}, hi, 0);
    check({tag, "_no_bytes"}, obs_q.size(), 0);
  endtask

  initial begin
    logic [7:0]      op;
    logic [XLEN-1:0] ra, rl;
    logic [7:0]      legal_ops [6];
    int              w;
    legal_ops = '{CPU_RST, CPU_RUN, CONF_WR, CONF_RD, DATA_WR, DATA_RD};
    rst_n = 1'b0; cmd = '0; cmd_addr = '0; cmd_len = '0; cmd_vld = 1'b0;
    pay_data = '0; pay_vld = 1'b0;
    len_model = '0;
    repeat (3) step();
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_vld", tx_vld, 0);
    check("rst_pay_rdy", pay_rdy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    step();
    check("idle_cmd_rdy", cmd_rdy, 1);

    $display("[TB] CPU_RST with busy transmitter");
    hold_cfg = 0; busy_cfg = 10;
    run_legal("cpu_rst", CPU_RST, '0, '0, 1'b0, -1, -1);

    $display("[TB] CONF_WR addr 0x40000000 len 0x1f");
    busy_cfg = 3;
    run_legal("conf_wr", CONF_WR, 32'h4000_0000, 32'h0000_001f, 1'b0, -1, -1);

    $display("[TB] DATA_WR 32 bytes with payload gaps");
    run_legal("data_wr", DATA_WR, '0, '0, 1'b1, 10, 20);

    $display("[TB] illegal opcode 0x30");
    run_illegal("illegal30", 8'h30);

    $display("[TB] ready held high after each transfer");
    hold_cfg = 3; busy_cfg = 2;
    run_legal("hold_rd", CONF_RD, '0, '0, 1'b0, -1, -1);
    run_legal("hold_wr", CONF_WR, $urandom, 32'h3, 1'b0, -1, -1);
    run_legal("hold_data", DATA_WR, '0, '0, 1'b0, -1, -1);

    $display("[TB] randomized commands");
    for (int k = 0; k < 10; k++) begin
      hold_cfg = $urandom_range(0, 2);
      busy_cfg = $urandom_range(1, 6);
      if ($urandom_range(0, 4) == 0) begin
        op = 8'($urandom_range(0, 255));
        if (cmd_legal(op)) op = op + 8'd8;
        run_illegal($sformatf("rnd%0d_illegal", k), op);
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
        ra = $urandom;
        rl = XLEN'($urandom_range(0, 7));
        run_legal($sformatf("rnd%0d", k), op, ra, rl, 1'b0, -1, -1);
      end
    end

    $display("[TB] reset in the middle of a CONF_WR frame");
    hold_cfg = 0; busy_cfg = 3;
    send_cmd(CONF_WR, 32'h1234_5678, 32'h0000_0009);
    w = 0;
    while (!(obs_q.size() >= 3 && tx_vld) && w < 500) begin
      step();
      w++;
    end
    check("midrst_reach_4th_byte", 64'(w < 500), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_vld_async", tx_vld, 0);
    check("midrst_cmd_rdy_async", cmd_rdy, 0);
    repeat (2) step();
    rst_n = 1'b1;
    len_model = '0;
    obs_q.delete();
    exp_q.delete();
    step();
    run_legal("post_rst_data", DATA_WR, '0, '0, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
